// File: rtl/prbs_fec_pkg.sv
// Shared types and constants for the PRBS randomizer + punctured K=7 convolutional encoder.
package prbs_fec_pkg;

  typedef enum logic [1:0] {
    RATE_1_2     = 2'b00,
    RATE_2_3     = 2'b01,
    RATE_3_4     = 2'b10,
    RATE_ILLEGAL = 2'b11
  } rate_e;

  typedef enum logic [1:0] {StIdle, StFill, StPreload, StEncode} fsm_e;

  localparam logic [6:0] G1 = 7'o171;
  localparam logic [6:0] G2 = 7'o133;

  // Emission slots: bit p of *_Y picks Y for slot p; bit p of *_ADV marks the
  // slot that retires an input bit (its other symbol is either emitted or punctured).
  localparam logic [3:0] PUNCT_Y_1_2   = 4'b0010;
  localparam logic [3:0] PUNCT_ADV_1_2 = 4'b0010;
  localparam logic [3:0] PUNCT_Y_2_3   = 4'b0110;
  localparam logic [3:0] PUNCT_ADV_2_3 = 4'b0110;
  localparam logic [3:0] PUNCT_Y_3_4   = 4'b0110;
  localparam logic [3:0] PUNCT_ADV_3_4 = 4'b1110;

  function automatic logic [3:0] punct_y(rate_e r);
    case (r)
      RATE_2_3: return PUNCT_Y_2_3;
      RATE_3_4: return PUNCT_Y_3_4;
      default:  return PUNCT_Y_1_2;
    endcase
  endfunction

  function automatic logic [3:0] punct_adv(rate_e r);
    case (r)
      RATE_2_3: return PUNCT_ADV_2_3;
      RATE_3_4: return PUNCT_ADV_3_4;
      default:  return PUNCT_ADV_1_2;
    endcase
  endfunction

  function automatic logic [1:0] punct_last(rate_e r);
    case (r)
      RATE_2_3: return 2'd2;
      RATE_3_4: return 2'd3;
      default:  return 2'd1;
    endcase
  endfunction

  function automatic int unsigned coded_len(rate_e r, int unsigned n);
    case (r)
      RATE_2_3: return (n * 3) / 2;
      RATE_3_4: return (n * 4) / 3;
      default:  return 2 * n;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// WiMAX randomizer LFSR (1 + x^14 + x^15); shared with the derandomizer.
module prbs_lfsr #(
  parameter int unsigned PRBS_LEN = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic [PRBS_LEN:1] seed,
  output logic              prbs_bit
);

  logic [PRBS_LEN:1] lfsr_q, lfsr_d;

  assign prbs_bit = lfsr_q[PRBS_LEN-1] ^ lfsr_q[PRBS_LEN];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      // seed MSB lands in stage 1
      for (int k = 1; k <= PRBS_LEN; k++) begin
        lfsr_d[k] = seed[PRBS_LEN+1-k];
      end
    end else if (enable) begin
      lfsr_d = {lfsr_q[PRBS_LEN-1:1], prbs_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= '0;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/prbs_fec_punct.sv
// Randomizer feeding a block-buffered tail-biting K=7 encoder with runtime puncturing
// and valid/ready flow control on both sides.
module prbs_fec_punct
  import prbs_fec_pkg::*;
#(
  parameter int unsigned BLOCK_BITS = 96,
  parameter int unsigned PRBS_LEN   = 15,
  parameter int unsigned K          = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [PRBS_LEN:1] seed,
  input  logic [1:0]        rate_sel,
  input  logic              in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              block_done,
  output logic              rate_err
);

  localparam int unsigned CntW = $clog2(BLOCK_BITS);
  localparam int unsigned SymW = $clog2(2 * BLOCK_BITS);

  fsm_e                  state_q, state_d;
  rate_e                 rate_q, rate_d;
  logic                  rate_err_q, rate_err_d;
  logic [CntW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]            phase_q, phase_d;
  logic [SymW-1:0]       sym_cnt_q, sym_cnt_d, sym_last;
  logic [K-2:0]          enc_q, enc_d;
  logic [BLOCK_BITS-1:0] buf_q, buf_d;
  logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic                  out_data_q, out_data_d, block_done_q, block_done_d;
  logic                  lfsr_load, lfsr_en, prbs_bit, accept;
  logic [3:0]            ymask, advmask;
  logic [K-1:0]          enc_vec;

  prbs_lfsr #(.PRBS_LEN(PRBS_LEN)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (lfsr_load),
    .enable   (lfsr_en),
    .seed     (seed),
    .prbs_bit (prbs_bit)
  );

  assign accept   = (state_q == StFill) && in_valid && in_ready_q;
  assign ymask    = punct_y(rate_q);
  assign advmask  = punct_adv(rate_q);
  assign sym_last = SymW'(coded_len(rate_q, BLOCK_BITS) - 1);

  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    rate_err_d = rate_err_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    phase_d    = phase_q;
    sym_cnt_d  = sym_cnt_q;
    enc_d      = enc_q;
    buf_d      = buf_q;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          if (rate_sel == RATE_ILLEGAL) begin
            rate_err_d = 1'b1;
          end else begin
            rate_err_d = 1'b0;
            rate_d     = rate_e'(rate_sel);
            lfsr_load  = 1'b1;
            wr_cnt_d   = '0;
            state_d    = StFill;
          end
        end
      end
      StFill: begin
        if (accept) begin
          lfsr_en         = 1'b1;
          buf_d[wr_cnt_q] = in_data ^ prbs_bit;
          wr_cnt_d        = wr_cnt_q + CntW'(1);
          if (wr_cnt_q == CntW'(BLOCK_BITS - 1)) begin
            wr_cnt_d = '0;
            state_d  = StPreload;
          end
        end
      end
      StPreload: begin
        // Tail-biting: start from the block's last K-1 bits, newest as s1.
        enc_d     = buf_q[BLOCK_BITS-1 -: K-1];
        rd_cnt_d  = '0;
        phase_d   = '0;
        sym_cnt_d = '0;
        state_d   = StEncode;
      end
      StEncode: begin
        if (out_ready) begin
          if (sym_cnt_q == sym_last) begin
            state_d = StIdle;
          end else begin
            sym_cnt_d = sym_cnt_q + SymW'(1);
            phase_d   = (phase_q == punct_last(rate_q)) ? 2'd0 : phase_q + 2'd1;
            if (advmask[phase_q]) begin
              enc_d    = {buf_q[rd_cnt_q], enc_q[K-2:1]};
              rd_cnt_d = rd_cnt_q + CntW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are precomputed from the next pointer so they appear registered.
  always_comb begin
    enc_vec      = {buf_q[rd_cnt_d], enc_d};
    in_ready_d   = (state_d == StFill);
    out_valid_d  = (state_d == StEncode);
    out_data_d   = 1'b0;
    block_done_d = 1'b0;
    if (out_valid_d) begin
      out_data_d   = ymask[phase_d] ? ^(enc_vec & G2) : ^(enc_vec & G1);
      block_done_d = (sym_cnt_d == sym_last);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rate_q       <= RATE_1_2;
      rate_err_q   <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      phase_q      <= '0;
      sym_cnt_q    <= '0;
      enc_q        <= '0;
      buf_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rate_q       <= rate_d;
      rate_err_q   <= rate_err_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      phase_q      <= phase_d;
      sym_cnt_q    <= sym_cnt_d;
      enc_q        <= enc_d;
      buf_q        <= buf_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      block_done_q <= block_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign block_done = block_done_q;
  assign rate_err   = rate_err_q;

endmodule
